fetch_unit: RTL and testbench

//  Instruction fetch stage, directly upstream of decode/control. Owns the PC, issues word reads to

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_queue.sv | 62 ++++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic {
    StFetch = 1'b0,
    StFlush = 1'b1
  } fetch_state_e;

  localparam int unsigned EntryWidth = 64;
  localparam logic [31:0] WordBytes = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with clear, full/empty flags and occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_queue #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, credit-limited imem requests, response queue, redirects.
// Define FETCH_STATS_EN to add the fetch_count / flush_count statistics ports.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CntW-1:0] discard_q, discard_d;

  logic [CntW-1:0] q_count, a_count;
  logic            q_full, q_empty, a_full, a_empty;
  logic [31:0]     a_head;
  fetch_entry_t    q_head, q_wdata;
  logic            grant, rsp, q_push, q_pop;
  logic [CntW:0]   credits_used;

  // Occupancy plus outstanding reads bounds the queue, so a response always has a slot.
  assign credits_used = {1'b0, q_count} + {1'b0, a_count};
  assign imem_req     = !reset && (state_q == StFetch) && !redirect_valid && !a_full &&
                        (credits_used < (CntW + 1)'(QUEUE_DEPTH));
  assign imem_addr    = pc_q;
  assign grant        = imem_req && imem_gnt;

  // The address FIFO holds exactly the in-flight reads; responses with none are stale.
  assign rsp     = imem_rvalid && !a_empty;
  assign q_pop   = if_valid && if_ready && !redirect_valid;
  assign q_push  = rsp && (discard_q == '0) && !redirect_valid && (!q_full || q_pop);
  assign q_wdata = '{pc: a_head, instr: imem_rdata};

  assign if_valid    = !q_empty;
  assign if_pc       = q_head.pc;
  assign if_instr    = q_head.instr;
  assign if_pc_plus4 = q_head.pc + WordBytes;

  fetch_queue #(
    .Width (EntryWidth),
    .Depth (QUEUE_DEPTH)
  ) u_instr_queue (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (redirect_valid),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .wdata_i (q_wdata),
    .rdata_o (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  fetch_queue #(
    .Width (32),
    .Depth (QUEUE_DEPTH)
  ) u_addr_queue (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (1'b0),
    .push_i  (grant),
    .pop_i   (rsp),
    .wdata_i (pc_q),
    .rdata_o (a_head),
    .full_o  (a_full),
    .empty_o (a_empty),
    .count_o (a_count)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;

    if (grant) begin
      pc_d = pc_q + WordBytes;
    end
    if (rsp && (discard_q != '0)) begin
      discard_d = discard_q - CntW'(1);
    end
    if ((state_q == StFlush) && (discard_d == '0)) begin
      state_d = StFetch;
    end

    // Redirect wins; every read still outstanding after this cycle becomes stale.
    if (redirect_valid) begin
      pc_d      = redirect_pc & ~32'h3;
      discard_d = a_count - CntW'(rsp);
      state_d   = (discard_d != '0) ? StFlush : StFetch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (q_pop) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (redirect_valid) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple in-order imem responder (1-cycle latency, holdable).
module tb_fetch_unit;

  localparam int unsigned QD  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk, reset;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, flush_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] pend [$];
  bit rsp_hold = 0;

  fetch_unit #(
    .RESET_PC    (RPC),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .flush_count    (flush_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory: records grants at negedge, answers one cycle later unless held.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem_req && imem_gnt) pend.push_back(imem_addr);
      @(posedge clk);
      #2;
      if (!rsp_hold && pend.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_gnt       = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    rsp_hold       = 0;
    repeat (6) step();
    pend.delete();
  endtask

  task automatic wait_valid(input string name);
    int w = 0;
    while (!if_valid && w < 12) begin
      step();
      #3;
      w++;
    end
    n_cmp++;
    if (if_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_timeout: if_valid got %b want 1", name, if_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL reset_req: got %b want 0", imem_req);
    end
    n_cmp++;
    if (if_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b want 0", if_valid);
    end
    n_cmp++;
    if (imem_addr !== RPC) begin
      n_err++; $display("FAIL reset_addr: got %h want %h", imem_addr, RPC);
    end
  endtask

  task automatic test_stream();
    int w = 0;
    logic [31:0] exp;
    do_reset();
    reset = 1'b0; imem_gnt = 1'b1; if_ready = 1'b1;
    #3;
    while (!if_valid && w < 10) begin
      step(); #3; w++;
    end
    n_cmp++;
    if (w !== 2) begin
      n_err++; $display("FAIL stream_latency: got %0d cycles want 2", w);
    end
    for (int k = 0; k < 6; k++) begin
      exp = 32'(4 * k);
      n_cmp++;
      if (if_valid !== 1'b1) begin
        n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", k, if_valid);
      end
      n_cmp++;
      if (if_pc !== exp) begin
        n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", k, if_pc, exp);
      end
      n_cmp++;
      if (if_pc_plus4 !== exp + 32'd4) begin
        n_err++; $display("FAIL stream_pc4[%0d]: got %h want %h", k, if_pc_plus4, exp + 32'd4);
      end
      n_cmp++;
      if (if_instr !== instr_of(exp)) begin
        n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", k, if_instr, instr_of(exp));
      end
      step(); #3;
    end
  endtask

  task automatic test_backpressure();
    int grants = 0;
    logic [31:0] exp;
    do_reset();
    reset = 1'b0; imem_gnt = 1'b1; if_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #3;
      if (imem_req && imem_gnt) grants++;
      step();
    end
    #3;
    n_cmp++;
    if (grants !== QD) begin
      n_err++; $display("FAIL bp_grants: got %0d want %0d", grants, QD);
    end
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL bp_req: got %b want 0", imem_req);
    end
    n_cmp++;
    if (if_pc !== 32'h0 || if_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_head_pc: got %h/%b want 00000000/1", if_pc, if_valid);
    end
    n_cmp++;
    if (if_instr !== instr_of(32'h0)) begin
      n_err++; $display("FAIL bp_head_instr: got %h want %h", if_instr, instr_of(32'h0));
    end
    if_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = 32'(4 * k);
      n_cmp++;
      if (if_pc !== exp || if_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_drain[%0d]: got %h/%b want %h/1", k, if_pc, if_valid, exp);
      end
      step(); #3;
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    reset = 1'b0; imem_gnt = 1'b1; if_ready = 1'b1; rsp_hold = 1;
    step();
    step();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #3;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL rd_req_redirect: got %b want 0", imem_req);
    end
    step();
    redirect_valid = 1'b0; rsp_hold = 0; imem_gnt = 1'b1;
    #3;
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
        n_err++; $display("FAIL rd_flush[%0d]: req/valid got %b/%b want 0/0", c, imem_req, if_valid);
      end
      step(); #3;
    end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_err++; $display("FAIL rd_resume: req/addr got %b/%h want 1/00000100", imem_req, imem_addr);
    end
    wait_valid("rd");
    n_cmp++;
    if (if_pc !== 32'h100) begin
      n_err++; $display("FAIL rd_first_pc: got %h want 00000100", if_pc);
    end
    n_cmp++;
    if (if_instr !== instr_of(32'h100)) begin
      n_err++; $display("FAIL rd_first_instr: got %h want %h", if_instr, instr_of(32'h100));
    end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    reset = 1'b0; imem_gnt = 1'b0; if_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3;
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
        n_err++; $display("FAIL stall_hold[%0d]: req/addr got %b/%h want 1/00000000", c, imem_req, imem_addr);
      end
      step();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #3;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL stall_redirect_req: got %b want 0", imem_req);
    end
    step();
    redirect_valid = 1'b0;
    #3;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_err++; $display("FAIL stall_new_addr: req/addr got %b/%h want 1/00000200", imem_req, imem_addr);
    end
    step();
    imem_gnt = 1'b1;
    #3;
    wait_valid("stall");
    n_cmp++;
    if (if_pc !== 32'h200) begin
      n_err++; $display("FAIL stall_first_pc: got %h want 00000200", if_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    reset = 1'b0; imem_gnt = 1'b0; if_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; imem_gnt = 1'b1;
    #3;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_addr_top: req/addr got %b/%h want 1/fffffffc", imem_req, imem_addr);
    end
    step(); #3;
    n_cmp++;
    if (imem_addr !== 32'h0) begin
      n_err++; $display("FAIL wrap_addr_next: got %h want 00000000", imem_addr);
    end
    wait_valid("wrap");
    n_cmp++;
    if (if_pc !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_pc: got %h want fffffffc", if_pc);
    end
    n_cmp++;
    if (if_pc_plus4 !== 32'h0) begin
      n_err++; $display("FAIL wrap_pc4: got %h want 00000000", if_pc_plus4);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    reset = 1'b0; imem_gnt = 1'b1; if_ready = 1'b0;
    step();
    step();
    step();
    rsp_hold = 1;
    step();
    reset = 1'b1; imem_gnt = 1'b0;
    #3;
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      n_err++; $display("FAIL mid_prefill: valid/pc got %b/%h want 1/00000000", if_valid, if_pc);
    end
    step();
    reset = 1'b0; rsp_hold = 0;
    #3;
    n_cmp++;
    if (if_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_valid_after: got %b want 0", if_valid);
    end
    n_cmp++;
    if (imem_addr !== RPC || imem_req !== 1'b1) begin
      n_err++; $display("FAIL mid_addr_after: req/addr got %b/%h want 1/%h", imem_req, imem_addr, RPC);
    end
`ifdef FETCH_STATS_EN
    n_cmp++;
    if (fetch_count !== 32'd0 || flush_count !== 32'd0) begin
      n_err++; $display("FAIL mid_counters: got %0d/%0d want 0/0", fetch_count, flush_count);
    end
`endif
    for (int c = 0; c < 2; c++) begin
      step(); #3;
      n_cmp++;
      if (if_valid !== 1'b0) begin
        n_err++; $display("FAIL mid_late_rvalid[%0d]: if_valid got %b want 0", c, if_valid);
      end
    end
    step();
    imem_gnt = 1'b1; if_ready = 1'b1;
    #3;
    wait_valid("mid");
    n_cmp++;
    if (if_pc !== RPC || if_instr !== instr_of(RPC)) begin
      n_err++; $display("FAIL mid_first: pc/instr got %h/%h want %h/%h", if_pc, if_instr, RPC, instr_of(RPC));
    end
`ifdef FETCH_STATS_EN
    step(); #3;
    n_cmp++;
    if (fetch_count !== 32'd1 || flush_count !== 32'd0) begin
      n_err++; $display("FAIL mid_counts_delivered: got %0d/%0d want 1/0", fetch_count, flush_count);
    end
`endif
  endtask

  initial begin
    reset          = 1'b1;
    imem_gnt       = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_gnt_stall();
    test_wrap();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
